// File: rtl/jeopardy_button_conditioner.sv
// Purpose : conditions raw asynchronous player buttons for the jeopardy FSM.
//           Per channel: two-flop synchroniser, counter debounce, and an
//           optional registered rising-edge (press) pulse.
// Latency : a level change on btn_raw appears on btn_clean 2+DEBOUNCE_CYCLES
//           edges later; btn_press rises on the same edge as btn_clean.
// Backpressure: none; free-running level conditioner with no handshake.
// Build option: define BUTTON_PRESS_PULSE_EN to build the press-pulse register;
//           when it is undefined, btn_press is tied to 0.
// Ports   : clock     - 100 Hz game clock, rising edge active
//           reset     - synchronous active-low reset
//           btn_raw   - raw button levels, 1 = pressed (asynchronous)
//           btn_clean - debounced levels, 1 = pressed
//           btn_press - one-cycle pulse on each debounced 0->1 transition
module jeopardy_button_conditioner #(
   parameter int N               = 3,
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int CNT_W           = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] btn_raw,
   output logic [N-1:0] btn_clean,
   output logic [N-1:0] btn_press
);

   // Count value at which one more disagreeing sample accepts the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]     sync1_q;
   logic [N-1:0]     sync2_q;
   logic [N-1:0]     clean_q;
   logic [N-1:0]     clean_d;
   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];

   // Debounce: count consecutive synchronised samples that disagree with
   // the accepted level. Any agreeing sample restarts the count, so the
   // counter can never exceed CNT_LAST.
   always_comb begin
      clean_d = clean_q;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               clean_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         clean_q <= '0;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign btn_clean = clean_q;

`ifdef BUTTON_PRESS_PULSE_EN
   logic [N-1:0] press_q;
   logic [N-1:0] press_d;

   // Registered alongside clean_q, so the pulse lines up with the cycle in
   // which btn_clean first reads 1. Releases produce no pulse.
   assign press_d = clean_d & ~clean_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         press_q <= '0;
      end else begin
         press_q <= press_d;
      end
   end

   assign btn_press = press_q;
`else
   assign btn_press = '0;
`endif

endmodule

// File: doc/jeopardy_button_conditioner.md
# jeopardy_button_conditioner

- Input stage in front of the jeopardy game state machine.
- Takes the raw, asynchronous, bouncing player push-buttons from the GPIO pins.
- Per channel: two-flop synchroniser, counter-based debounce and rising-edge detector, all clocked on the 100 Hz game clock.
- Outputs clean debounced levels and optional one-cycle press pulses, which feed the FSM's button inputs directly.

## Interface
- `N`, default 3: number of button channels (one per player; minimum 1).
- `DEBOUNCE_CYCLES`, default 3: consecutive agreeing synchronised samples required to accept a new level (minimum 1; 30 ms at 100 Hz).
- `CNT_W`, default 4: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clock` input 1: game clock (100 Hz); all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `btn_raw` input N: raw asynchronous button levels, 1 = pressed.
- `btn_clean` output N: debounced level per channel, 1 = pressed.
- `btn_press` output N: one-cycle pulse on each debounced 0→1 transition.

## Operation
Per channel i, fully independent:
- `sync1[i]` <= `btn_raw[i]`; `sync2[i]` <= `sync1[i]`. Only `sync2` is used downstream.
- If `sync2[i]` == `btn_clean[i]`: `cnt[i]` <= 0.
- If they differ and `cnt[i]` < DEBOUNCE_CYCLES-1: `cnt[i]` <= `cnt[i]`+1.
- If they differ and `cnt[i]` == DEBOUNCE_CYCLES-1: `btn_clean[i]` <= `sync2[i]` and `cnt[i]` <= 0.
- Any sample agreeing with `btn_clean` before the count completes restarts qualification from 0. Glitches shorter than DEBOUNCE_CYCLES synchronised samples are rejected.
- `btn_press[i]` <= 1 exactly in the cycle where `btn_clean[i]` goes 0→1; otherwise 0. Release (1→0) produces no pulse.
- Channels never arbitrate against each other. Simultaneous presses on several channels yield simultaneous pulses. Player priority is left to the FSM.
- The counter saturates by construction: it never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

## Timing
- While `reset` is sampled low, all of the following are 0: `sync1`, `sync2`, `cnt`, `btn_clean`, `btn_press`.
- Latency: if `btn_raw[i]` rises before edge 1 and stays high:
  - `sync2` is high after edge 2.
  - `btn_clean[i]` is high after edge 2+DEBOUNCE_CYCLES.
  - `btn_press[i]` is high for exactly the clock cycle following that edge.
  - With defaults, 5 edges (50 ms).
- Release latency is identical: 2+DEBOUNCE_CYCLES edges.
- DEBOUNCE_CYCLES = 1: `btn_clean` follows `sync2` with one edge of delay.
- Reset mid-qualification discards the partial count. A button still held when reset rises re-qualifies in 2+DEBOUNCE_CYCLES edges counted from the first edge with `reset` high, then produces a press pulse.
- A button held through reset therefore always generates one press pulse after reset. This is required behaviour: the FSM treats it as a press.

## Configuration
- Macro: `BUTTON_PRESS_PULSE_EN`.
- Defined: edge-detect register present; `btn_press` behaves as specified above.
- Undefined: edge-detect logic is not built; `btn_press` is constant 0.
- `btn_clean` and its timing are identical in both builds.
- The FSM consumes `btn_clean` by default. The pulse output exists for the timer/scoring stages.

## Test plan
Defaults throughout (N=3, DEBOUNCE_CYCLES=3).
1. Reset: hold `reset`=0 for 2 edges with `btn_raw`=3'b111 → `btn_clean`=3'b000, `btn_press`=3'b000. Release reset with buttons held → `btn_clean`=3'b111 after the 5th edge; `btn_press`=3'b111 for one cycle, then 3'b000.
2. Clean press: `btn_raw[0]` 0→1 and held → `btn_clean`=3'b001 after edge 5; `btn_press`=3'b001 for exactly one cycle. Release → `btn_clean`=3'b000 after 5 further edges; no pulse.
3. Bounce rejection: `btn_raw[1]` pattern 1,1,0,1,1,0 (one value per cycle) → `btn_clean[1]` stays 0, no pulse. Then a steady 1 → `btn_clean[1]`=1 five edges after the steady value begins.
4. Simultaneous: `btn_raw`=3'b000→3'b101 on the same cycle → `btn_clean`=3'b101 and `btn_press`=3'b101 in the same cycle.
5. Reset mid-qualification: press `btn_raw[2]`, assert `reset`=0 at edge 4 for one edge, keep button held → no pulse before reset. `btn_clean[2]`=1 and pulse 5 edges after reset returns high.
6. `BUTTON_PRESS_PULSE_EN` undefined: rerun scenario 2 → identical `btn_clean` waveform; `btn_press` constant 3'b000.
